// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Latency: req sampled in IDLE at edge N -> ack/tx_start/active during cycle N+1.
// Backpressure: requesters hold req until ack; no grant while tx_busy or a frame is open.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDW          = 2,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t         state;
    logic [IDW-1:0] last;
    logic [7:0]     cnt;

    logic [7:0]     req_byte [NUM_REQ];
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = last;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(last) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last        <= IDW'(NUM_REQ - 1);
            cnt         <= 8'd0;
            ack         <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            grant_id    <= '0;
            active      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ack         <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && !tx_busy) begin
                        tx_data   <= req_byte[win];
                        grant_id  <= win;
                        last      <= win;
                        ack[win]  <= 1'b1;
                        tx_start  <= 1'b1;
                        active    <= 1'b1;
                        cnt       <= 8'd0;
                        state     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt + 8'd1 == 8'(BUSY_TIMEOUT)) begin
                        // Transmitter never acknowledged the start; give up on this byte.
                        err_timeout <= 1'b1;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        active <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
